worley_point_scheduler: RTL and testbench

- Per-frame sequencer for the Worley-noise feature points.
- On each frame tick it walks all N_PTS points, one axis per cycle, using a single shared step/reflect unit. It moves each point by its signed velocity and bounces it off the screen edges.
- The new coordinate set is published atomically, so the pixel datapath only ever sees a consistent set.
- Sits between hvsync_generator (frame tick) and the noise datapath (point coordinate inputs).

---
 rtl/worley_sched_pkg.sv | 11 +
 rtl/worley_axis_step.sv | 25 ++
 rtl/worley_point_scheduler.sv | 125 ++++++++++++
 tb/tb_worley_point_scheduler.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/worley_sched_pkg.sv
// worley_sched_pkg: state encoding, widths and reset defaults for the Worley point scheduler
package worley_sched_pkg;
  localparam int MAX_PTS = 8;
  localparam int IDX_W = 3;
  localparam int FCNT_W = 20;
  typedef enum logic [1:0] {IDLE, STEP_X, STEP_Y, PUBLISH} state_t;
  localparam int DEF_X [MAX_PTS] = '{100, 300, 500, 100, 0, 0, 0, 0};
  localparam int DEF_Y [MAX_PTS] = '{100, 200, 400, 300, 0, 0, 0, 0};
  localparam int DEF_VX [MAX_PTS] = '{1, -1, 2, -1, 0, 0, 0, 0};
  localparam int DEF_VY [MAX_PTS] = '{-1, 1, -1, -2, 0, 0, 0, 0};
endpackage

// File: rtl/worley_axis_step.sv
// worley_axis_step: one-axis move by signed velocity with single edge reflection
module worley_axis_step #(
  parameter int COORD_W = 10,
  parameter int VEL_W = 4
) (
  input  logic [COORD_W-1:0]      p,
  input  logic signed [VEL_W-1:0] v,
  input  logic [COORD_W-1:0]      max,
  output logic [COORD_W-1:0]      p_n,
  output logic signed [VEL_W-1:0] v_n
);
  localparam int SW = COORD_W + 2;
  localparam logic signed [VEL_W-1:0] VMIN = {1'b1, {(VEL_W-1){1'b0}}};
  logic signed [SW-1:0] s, sm, r;
  logic hi, lo;
  always_comb begin
    sm = $signed({2'b00, max});
    s = $signed({2'b00, p}) + $signed({{(SW-VEL_W){v[VEL_W-1]}}, v});
    hi = s > sm;
    lo = s[SW-1];
    r = hi ? (sm <<< 1) - s : lo ? -s : s;
    p_n = COORD_W'(r);
    v_n = (hi || lo) ? (v == VMIN ? ~VMIN : -v) : v;
  end
endmodule

// File: rtl/worley_point_scheduler.sv
// worley_point_scheduler: per-frame feature point sweep with atomic publish; WORLEY_SCHED_PAUSE_EN adds a pause input
module worley_point_scheduler import worley_sched_pkg::*; #(
  parameter int N_PTS = 4,
  parameter int COORD_W = 10,
  parameter int VEL_W = 4,
  parameter int X_MAX = 639,
  parameter int Y_MAX = 479
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       frame_tick,
`ifdef WORLEY_SCHED_PAUSE_EN
  input  logic                       pause,
`endif
  input  logic                       cfg_we,
  output logic                       cfg_ready,
  input  logic [IDX_W-1:0]           cfg_idx,
  input  logic [COORD_W-1:0]         cfg_x,
  input  logic [COORD_W-1:0]         cfg_y,
  input  logic [VEL_W-1:0]           cfg_vx,
  input  logic [VEL_W-1:0]           cfg_vy,
  output logic [N_PTS*COORD_W-1:0]   pts_x,
  output logic [N_PTS*COORD_W-1:0]   pts_y,
  output logic                       busy,
  output logic                       done,
  output logic [FCNT_W-1:0]          frame_cnt,
  output logic                       overrun
);
  localparam int IW = $clog2(N_PTS);
  state_t state;
  logic [IW-1:0] idx, ci;
  logic [COORD_W-1:0] wx [N_PTS];
  logic [COORD_W-1:0] wy [N_PTS];
  logic [COORD_W-1:0] px [N_PTS];
  logic [COORD_W-1:0] py [N_PTS];
  logic signed [VEL_W-1:0] vx [N_PTS];
  logic signed [VEL_W-1:0] vy [N_PTS];
  logic [COORD_W-1:0] sp, sp_n, smax, cx, cy;
  logic signed [VEL_W-1:0] sv, sv_n;
  logic cfg_ok, go;
  always_comb begin
    sp = state == STEP_Y ? wy[idx] : wx[idx];
    sv = state == STEP_Y ? vy[idx] : vx[idx];
    smax = state == STEP_Y ? COORD_W'(Y_MAX) : COORD_W'(X_MAX);
    cx = cfg_x > COORD_W'(X_MAX) ? COORD_W'(X_MAX) : cfg_x;
    cy = cfg_y > COORD_W'(Y_MAX) ? COORD_W'(Y_MAX) : cfg_y;
    ci = IW'(cfg_idx);
    cfg_ok = cfg_we && cfg_ready && (32'(cfg_idx) < N_PTS);
`ifdef WORLEY_SCHED_PAUSE_EN
    go = frame_tick && !pause;
`else
    go = frame_tick;
`endif
  end
  worley_axis_step #(.COORD_W(COORD_W), .VEL_W(VEL_W)) u_step (
    .p(sp), .v(sv), .max(smax), .p_n(sp_n), .v_n(sv_n)
  );
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      idx <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      cfg_ready <= 1'b1;
      frame_cnt <= '0;
      overrun <= 1'b0;
      for (int i = 0; i < N_PTS; i++) begin
        wx[i] <= COORD_W'(DEF_X[i]);
        wy[i] <= COORD_W'(DEF_Y[i]);
        px[i] <= COORD_W'(DEF_X[i]);
        py[i] <= COORD_W'(DEF_Y[i]);
        vx[i] <= VEL_W'(DEF_VX[i]);
        vy[i] <= VEL_W'(DEF_VY[i]);
      end
    end else begin
      done <= 1'b0;
      // config lands before a same-cycle tick's first step reads the working set
      if (cfg_ok) begin
        wx[ci] <= cx;
        wy[ci] <= cy;
        px[ci] <= cx;
        py[ci] <= cy;
        vx[ci] <= cfg_vx;
        vy[ci] <= cfg_vy;
      end
      if (frame_tick && busy) overrun <= 1'b1;
      case (state)
        IDLE: if (go) begin
          state <= STEP_X;
          idx <= '0;
          busy <= 1'b1;
          cfg_ready <= 1'b0;
        end
        STEP_X: begin
          wx[idx] <= sp_n;
          vx[idx] <= sv_n;
          state <= STEP_Y;
        end
        STEP_Y: begin
          wy[idx] <= sp_n;
          vy[idx] <= sv_n;
          if (idx == IW'(N_PTS - 1)) begin
            state <= PUBLISH;
            done <= 1'b1;
          end else begin
            state <= STEP_X;
            idx <= idx + 1'b1;
          end
        end
        default: begin
          px <= wx;
          py <= wy;
          frame_cnt <= frame_cnt + 1'b1;
          state <= IDLE;
          busy <= 1'b0;
          cfg_ready <= 1'b1;
        end
      endcase
    end
  end
  for (genvar i = 0; i < N_PTS; i++) begin : g_pack
    assign pts_x[i*COORD_W +: COORD_W] = px[i];
    assign pts_y[i*COORD_W +: COORD_W] = py[i];
  end
endmodule

// File: tb/tb_worley_point_scheduler.sv
// tb_worley_point_scheduler: randomized scoreboard bench against an arithmetic point model
module tb_worley_point_scheduler;
  logic clk = 0, reset = 1, frame_tick = 0, cfg_we = 0;
  logic [2:0] cfg_idx = 0;
  logic [9:0] cfg_x = 0, cfg_y = 0;
  logic [3:0] cfg_vx = 0, cfg_vy = 0;
  logic cfg_ready, busy, done, overrun;
  logic [39:0] pts_x, pts_y;
  logic [19:0] frame_cnt;
  typedef struct {logic [39:0] x; logic [39:0] y; int fc; int dc;} exp_t;
  exp_t exp_q[$];
  exp_t me;
  int mx[8], my[8], mvx[8], mvy[8], mfc;
  int checks = 0, failures = 0, cyc = 0, done_cnt = 0;

  worley_point_scheduler dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick),
`ifdef WORLEY_SCHED_PAUSE_EN
    .pause(1'b0),
`endif
    .cfg_we(cfg_we), .cfg_ready(cfg_ready), .cfg_idx(cfg_idx), .cfg_x(cfg_x), .cfg_y(cfg_y),
    .cfg_vx(cfg_vx), .cfg_vy(cfg_vy), .pts_x(pts_x), .pts_y(pts_y), .busy(busy), .done(done),
    .frame_cnt(frame_cnt), .overrun(overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    int dx[8] = '{100, 300, 500, 100, 0, 0, 0, 0};
    int dy[8] = '{100, 200, 400, 300, 0, 0, 0, 0};
    int dvx[8] = '{1, -1, 2, -1, 0, 0, 0, 0};
    int dvy[8] = '{-1, 1, -1, -2, 0, 0, 0, 0};
    for (int i = 0; i < 8; i++) begin
      mx[i] = dx[i]; my[i] = dy[i]; mvx[i] = dvx[i]; mvy[i] = dvy[i];
    end
    mfc = 0;
  endfunction

  function automatic int bounce_p(int p, int v, int m);
    int s = p + v;
    return s > m ? 2 * m - s : (s < 0 ? -s : s);
  endfunction

  function automatic int bounce_v(int p, int v, int m);
    int s = p + v;
    if (s > m || s < 0) return (-v > 7) ? 7 : -v;
    return v;
  endfunction

  function automatic logic [39:0] pk(input bit is_y);
    logic [39:0] r;
    for (int i = 0; i < 4; i++) r[i*10 +: 10] = 10'(is_y ? my[i] : mx[i]);
    return r;
  endfunction

  function automatic void model_cfg(int idx, int x, int y, int vx, int vy);
    if (idx >= 4) return;
    mx[idx] = x > 639 ? 639 : x;
    my[idx] = y > 479 ? 479 : y;
    mvx[idx] = vx;
    mvy[idx] = vy;
  endfunction

  function automatic void model_sweep(int tc);
    exp_t e;
    int nv;
    for (int i = 0; i < 4; i++) begin
      nv = bounce_v(mx[i], mvx[i], 639); mx[i] = bounce_p(mx[i], mvx[i], 639); mvx[i] = nv;
      nv = bounce_v(my[i], mvy[i], 479); my[i] = bounce_p(my[i], mvy[i], 479); mvy[i] = nv;
    end
    mfc = (mfc + 1) % (1 << 20);
    e.x = pk(0); e.y = pk(1); e.fc = mfc; e.dc = tc + 9;
    exp_q.push_back(e);
  endfunction

  task automatic pulse(input bit t, input bit we, input int idx, input int x, input int y,
                       input int vx, input int vy);
    frame_tick = t; cfg_we = we; cfg_idx = 3'(idx);
    cfg_x = 10'(x); cfg_y = 10'(y); cfg_vx = 4'(vx); cfg_vy = 4'(vy);
    @(posedge clk); #1;
    frame_tick = 0; cfg_we = 0;
  endtask

  task automatic wait_idle(input int tc);
    for (int k = 0; k < 40 && busy; k++) begin @(posedge clk); #1; end
    chk("idle_cycle", cyc, tc + 10);
    @(posedge clk); #1;
  endtask

  task automatic op(input bit t, input bit we, input int idx, input int x, input int y,
                    input int vx, input int vy);
    int tc = cyc;
    if (we) model_cfg(idx, x, y, vx, vy);
    if (t) model_sweep(tc);
    pulse(t, we, idx, x, y, vx, vy);
    if (t) wait_idle(tc);
  endtask

  // monitor: every done pulse must match the oldest expectation
  initial forever begin
    @(negedge clk);
    if (done === 1'b1) begin
      done_cnt++;
      if (exp_q.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        me = exp_q.pop_front();
        chk("done_cycle", cyc, me.dc);
        @(posedge clk); #1;
        chk("pub_x", pts_x, me.x);
        chk("pub_y", pts_y, me.y);
        chk("frame_cnt", frame_cnt, me.fc);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    int tc, dc, rt, rw, ri, rx, ry, rvx, rvy;
    model_reset();
    repeat (3) @(posedge clk);
    #1 reset = 0;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_cfg_ready", cfg_ready, 1);
    chk("rst_frame_cnt", frame_cnt, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_pts_x", pts_x, pk(0));
    chk("rst_pts_y", pts_y, pk(1));
    tc = cyc; model_sweep(tc);
    pulse(1, 0, 0, 0, 0, 0, 0);
    chk("busy_c1", busy, 1);
    chk("cfg_ready_busy", cfg_ready, 0);
    wait_idle(tc);
    op(0, 1, 2, 636, my[2], 7, mvy[2]);
    chk("cfg_pub_x", pts_x, pk(0));
    op(1, 0, 0, 0, 0, 0, 0);
    op(1, 0, 0, 0, 0, 0, 0);
    op(0, 1, 0, mx[0], 1, mvx[0], -3);
    op(1, 0, 0, 0, 0, 0, 0);
    op(0, 1, 0, mx[0], 0, mvx[0], -8);
    chk("cfg_pub_y", pts_y, pk(1));
    op(1, 0, 0, 0, 0, 0, 0);
    op(1, 0, 0, 0, 0, 0, 0);
    chk("overrun_clear", overrun, 0);
    tc = cyc; model_sweep(tc);
    pulse(1, 0, 0, 0, 0, 0, 0);
    repeat (3) begin @(posedge clk); #1; end
    pulse(1, 0, 0, 0, 0, 0, 0);
    wait_idle(tc);
    chk("overrun_set", overrun, 1);
    tc = cyc; model_sweep(tc);
    pulse(1, 0, 0, 0, 0, 0, 0);
    repeat (2) begin @(posedge clk); #1; end
    chk("cfg_ready_mid", cfg_ready, 0);
    pulse(0, 1, 1, 5, 5, 3, 3);
    wait_idle(tc);
    op(0, 1, 5, 7, 7, 1, 1);
    chk("bad_idx_x", pts_x, pk(0));
    chk("bad_idx_y", pts_y, pk(1));
    op(1, 0, 0, 0, 0, 0, 0);
    op(1, 1, 3, 638, 478, 7, 7);
    op(1, 1, 1, 0, 0, -8, -8);
    for (int n = 0; n < 30; n++) begin
      rt = ($urandom % 3) != 0; rw = $urandom % 2; ri = $urandom % 8;
      rx = $urandom % 1024; ry = $urandom % 1024;
      rvx = int'($urandom % 16) - 8; rvy = int'($urandom % 16) - 8;
      op(rt[0], rw[0], ri, rx, ry, rvx, rvy);
      if (rw != 0 && rt == 0) begin
        chk("rnd_cfg_x", pts_x, pk(0));
        chk("rnd_cfg_y", pts_y, pk(1));
      end
    end
    tc = cyc; model_sweep(tc);
    pulse(1, 0, 0, 0, 0, 0, 0);
    repeat (4) begin @(posedge clk); #1; end
    reset = 1;
    exp_q.delete();
    model_reset();
    dc = done_cnt;
    repeat (2) begin @(posedge clk); #1; end
    reset = 0;
    repeat (12) begin @(posedge clk); #1; end
    chk("abort_no_done", done_cnt, dc);
    chk("abort_pts_x", pts_x, pk(0));
    chk("abort_pts_y", pts_y, pk(1));
    chk("abort_frame_cnt", frame_cnt, 0);
    chk("abort_overrun", overrun, 0);
    op(1, 0, 0, 0, 0, 0, 0);
    repeat (3) begin @(posedge clk); #1; end
    chk("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
